// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction attributes going into the forwarding/hazard controller and the
// forward-select / pipeline-control results coming back out of it.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_md_start;
  logic              id_hilo_read;
  logic              flush;
  logic [1:0]        forward_op1;
  logic [1:0]        forward_op2;
  logic              stall;
  logic              bubble;
  logic              md_busy;

  // Pipeline side: drives the decoded ID instruction, consumes the controls.
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_regwrite, id_memread,
           id_md_start, id_hilo_read, flush,
    input  forward_op1, forward_op2, stall, bubble, md_busy
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_regwrite, id_memread,
           id_md_start, id_hilo_read, flush,
    output forward_op1, forward_op2, stall, bubble, md_busy
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline: shadows EXE/MEM/WB register
// writes, picks ALU operand forwards and raises load-use / HI-LO stalls and bubbles.
module fwd_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 8,
  parameter int unsigned REG_AW     = 5
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  localparam logic [3:0]        MD_LOAD  = 4'(MD_LATENCY);
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // EXE slot
  logic [REG_AW-1:0] r_exe_rs;
  logic [REG_AW-1:0] r_exe_rt;
  logic              r_exe_use_rs;
  logic              r_exe_use_rt;
  logic [REG_AW-1:0] r_exe_dest;
  logic              r_exe_regwrite;
  logic              r_exe_memread;
  // MEM slot
  logic [REG_AW-1:0] r_mem_dest;
  logic              r_mem_regwrite;
  logic              r_mem_memread;
  // WB slot; a load's memread no longer matters once its data is on the WB bus
  logic [REG_AW-1:0] r_wb_dest;
  logic              r_wb_regwrite;
  // HI/LO occupancy
  logic [3:0]        r_md_cnt;

  logic              w_lu;
  logic              w_mh;
  logic              w_md_busy;
  logic              w_stall;
  logic              w_bubble;
  logic [3:0]        w_md_cnt_d;
  logic [1:0]        w_fwd_op1;
  logic [1:0]        w_fwd_op2;

  // MEM beats WB so the youngest value wins; a load in MEM has no data yet and r0 is hardwired.
  function automatic logic [1:0] fwd_sel(
    input logic              use_src,
    input logic [REG_AW-1:0] src,
    input logic              mem_rw,
    input logic              mem_mr,
    input logic [REG_AW-1:0] mem_dest,
    input logic              wb_rw,
    input logic [REG_AW-1:0] wb_dest
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (use_src && (src != REG_ZERO)) begin
      if (mem_rw && !mem_mr && (mem_dest == src)) begin
        sel = 2'd2;
      end else if (wb_rw && (wb_dest == src)) begin
        sel = 2'd1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    w_fwd_op1 = fwd_sel(r_exe_use_rs, r_exe_rs, r_mem_regwrite, r_mem_memread, r_mem_dest,
                        r_wb_regwrite, r_wb_dest);
    w_fwd_op2 = fwd_sel(r_exe_use_rt, r_exe_rt, r_mem_regwrite, r_mem_memread, r_mem_dest,
                        r_wb_regwrite, r_wb_dest);
  end

  always_comb begin
    w_lu = r_exe_memread && r_exe_regwrite && (r_exe_dest != REG_ZERO) &&
           ((bus.id_use_rs && (bus.id_rs == r_exe_dest)) ||
            (bus.id_use_rt && (bus.id_rt == r_exe_dest)));
    w_md_busy = (r_md_cnt != 4'd0);
    w_mh      = w_md_busy && (bus.id_hilo_read || bus.id_md_start);
    w_stall   = (w_lu || w_mh) && !bus.flush;
    w_bubble  = w_lu || w_mh || bus.flush;
  end

  // A stalled or squashed MULT/DIV must not claim the unit; the count keeps draining regardless.
  always_comb begin
    w_md_cnt_d = r_md_cnt;
    if (bus.id_md_start && !w_stall && !bus.flush) begin
      w_md_cnt_d = MD_LOAD;
    end else if (r_md_cnt != 4'd0) begin
      w_md_cnt_d = r_md_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exe_rs       <= '0;
      r_exe_rt       <= '0;
      r_exe_use_rs   <= 1'b0;
      r_exe_use_rt   <= 1'b0;
      r_exe_dest     <= '0;
      r_exe_regwrite <= 1'b0;
      r_exe_memread  <= 1'b0;
      r_mem_dest     <= '0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_wb_dest      <= '0;
      r_wb_regwrite  <= 1'b0;
      r_md_cnt       <= 4'd0;
    end else begin
      r_wb_dest      <= r_mem_dest;
      r_wb_regwrite  <= r_mem_regwrite;
      r_mem_dest     <= r_exe_dest;
      r_mem_regwrite <= r_exe_regwrite;
      r_mem_memread  <= r_exe_memread;
      if (w_bubble) begin
        r_exe_rs       <= '0;
        r_exe_rt       <= '0;
        r_exe_use_rs   <= 1'b0;
        r_exe_use_rt   <= 1'b0;
        r_exe_dest     <= '0;
        r_exe_regwrite <= 1'b0;
        r_exe_memread  <= 1'b0;
      end else begin
        r_exe_rs       <= bus.id_rs;
        r_exe_rt       <= bus.id_rt;
        r_exe_use_rs   <= bus.id_use_rs;
        r_exe_use_rt   <= bus.id_use_rt;
        r_exe_dest     <= bus.id_dest;
        r_exe_regwrite <= bus.id_regwrite;
        r_exe_memread  <= bus.id_memread;
      end
      r_md_cnt <= w_md_cnt_d;
    end
  end

  assign bus.forward_op1 = w_fwd_op1;
  assign bus.forward_op2 = w_fwd_op2;
  assign bus.stall       = w_stall;
  assign bus.bubble      = w_bubble;
  assign bus.md_busy     = w_md_busy;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: a reference pipeline model pushes expected controls
// as each ID instruction is driven; they are popped and compared when the DUT outputs settle.
module tb_fwd_hazard_ctrl;

  localparam int unsigned LAT = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       md;
    logic       hr;
    logic       fl;
  } instr_t;

  typedef struct packed {
    logic [1:0] op1;
    logic [1:0] op2;
    logic       stall;
    logic       bubble;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst_n;

  fwd_hazard_ctrl_if #(.REG_AW(5)) bus ();

  fwd_hazard_ctrl #(.MD_LATENCY(LAT), .REG_AW(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_total = 0;
  int     n_bad   = 0;
  exp_t   exp_q[$];
  instr_t prog[$];

  // Reference pipeline state
  instr_t m_exe, m_mem, m_wb;
  int     m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic instr_t mk_nop();
    return '0;
  endfunction

  function automatic instr_t mk_alu(int d, int s, int t);
    instr_t i = '0;
    i.rs = 5'(s); i.rt = 5'(t); i.use_rs = 1'b1; i.use_rt = 1'b1;
    i.dest = 5'(d); i.rw = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_lw(int d, int base);
    instr_t i = '0;
    i.rs = 5'(base); i.use_rs = 1'b1; i.dest = 5'(d); i.rw = 1'b1; i.mr = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_mult(int s, int t);
    instr_t i = '0;
    i.rs = 5'(s); i.rt = 5'(t); i.use_rs = 1'b1; i.use_rt = 1'b1; i.md = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_mflo(int d);
    instr_t i = '0;
    i.dest = 5'(d); i.rw = 1'b1; i.hr = 1'b1;
    return i;
  endfunction

  function automatic instr_t flushed(instr_t i);
    instr_t r = i;
    r.fl = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] model_fwd(logic u, logic [4:0] s);
    if (!u || s == 5'd0) return 2'd0;
    if (m_mem.rw && !m_mem.mr && m_mem.dest == s) return 2'd2;
    if (m_wb.rw && m_wb.dest == s) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t model_out(instr_t i);
    exp_t e;
    logic lu, mh;
    lu = m_exe.mr && m_exe.rw && (m_exe.dest != 5'd0) &&
         ((i.use_rs && i.rs == m_exe.dest) || (i.use_rt && i.rt == m_exe.dest));
    mh = (m_cnt != 0) && (i.hr || i.md);
    e.op1    = model_fwd(m_exe.use_rs, m_exe.rs);
    e.op2    = model_fwd(m_exe.use_rt, m_exe.rt);
    e.stall  = (lu || mh) && !i.fl;
    e.bubble = lu || mh || i.fl;
    e.busy   = (m_cnt != 0);
    return e;
  endfunction

  task automatic drive(instr_t i);
    bus.id_rs        = i.rs;
    bus.id_rt        = i.rt;
    bus.id_use_rs    = i.use_rs;
    bus.id_use_rt    = i.use_rt;
    bus.id_dest      = i.dest;
    bus.id_regwrite  = i.rw;
    bus.id_memread   = i.mr;
    bus.id_md_start  = i.md;
    bus.id_hilo_read = i.hr;
    bus.flush        = i.fl;
  endtask

  task automatic compare_out(input string pfx);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s scoreboard empty t=%0t", pfx, $time);
      return;
    end
    e = exp_q.pop_front();
    chk({pfx, ".op1"},    32'(bus.forward_op1), 32'(e.op1));
    chk({pfx, ".op2"},    32'(bus.forward_op2), 32'(e.op2));
    chk({pfx, ".stall"},  32'(bus.stall),       32'(e.stall));
    chk({pfx, ".bubble"}, 32'(bus.bubble),      32'(e.bubble));
    chk({pfx, ".busy"},   32'(bus.md_busy),     32'(e.busy));
  endtask

  task automatic model_clear();
    m_exe = '0;
    m_mem = '0;
    m_wb  = '0;
    m_cnt = 0;
  endtask

  // One pipeline cycle; the ID instruction is held (not popped) while the model says stall.
  // With rst_here the reset is asserted mid-cycle, after the normal comparison.
  task automatic run_cycle(input string pfx, input bit rst_here = 1'b0);
    instr_t i;
    exp_t   e;
    @(negedge clk);
    i = (prog.size() != 0) ? prog[0] : mk_nop();
    drive(i);
    e = model_out(i);
    exp_q.push_back(e);
    #1;
    compare_out(pfx);
    if (rst_here) begin
      bus.flush = 1'b0;
      rst_n = 1'b0;
      #1;
      exp_q.push_back('0);
      compare_out({pfx, ".rst"});
      model_clear();
      prog.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      return;
    end
    @(posedge clk);
    m_wb  = m_mem;
    m_mem = m_exe;
    m_exe = e.bubble ? mk_nop() : i;
    if (i.md && !e.stall && !i.fl) m_cnt = LAT;
    else if (m_cnt != 0) m_cnt = m_cnt - 1;
    if (!e.stall && prog.size() != 0) void'(prog.pop_front());
  endtask

  task automatic run_prog(input string pfx, input int cycles);
    for (int c = 0; c < cycles; c++) run_cycle(pfx);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(mk_nop());
    model_clear();
    #2;
    exp_q.push_back('0);
    compare_out("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // EXE/MEM forward on rs
    prog.push_back(mk_alu(3, 1, 2));
    prog.push_back(mk_alu(4, 3, 1));
    run_prog("fwd_mem", 5);

    // WB forward on rt, then MEM-over-WB priority
    prog.push_back(mk_alu(3, 1, 2));
    prog.push_back(mk_nop());
    prog.push_back(mk_alu(6, 1, 3));
    prog.push_back(mk_alu(3, 1, 2));
    prog.push_back(mk_alu(3, 2, 1));
    prog.push_back(mk_alu(7, 2, 3));
    run_prog("fwd_wb", 9);

    // Load-use, then loads/uses of r0
    prog.push_back(mk_lw(5, 1));
    prog.push_back(mk_alu(6, 5, 1));
    prog.push_back(mk_lw(0, 1));
    prog.push_back(mk_alu(6, 0, 0));
    run_prog("loaduse", 9);

    // MULT then MFLO, then MULT back to back
    prog.push_back(mk_mult(1, 2));
    prog.push_back(mk_mflo(8));
    run_prog("md_mflo", 8);
    prog.push_back(mk_mult(1, 2));
    prog.push_back(mk_mult(3, 4));
    run_prog("md_mult", 12);

    // Flush of a load-use consumer and of an MD start
    prog.push_back(mk_lw(5, 1));
    prog.push_back(flushed(mk_alu(6, 5, 5)));
    prog.push_back(flushed(mk_mult(1, 2)));
    prog.push_back(mk_mflo(9));
    run_prog("flush", 6);
    prog.push_back(mk_mult(1, 2));
    prog.push_back(flushed(mk_mflo(9)));
    run_prog("flush_md", 8);

    // Reset mid-MULT (stalled MFLO) and mid load-use stall
    prog.push_back(mk_mult(1, 2));
    prog.push_back(mk_mflo(8));
    run_prog("rst_md", 2);
    run_cycle("rst_md", 1'b1);
    prog.push_back(mk_alu(3, 1, 2));
    prog.push_back(mk_alu(4, 3, 3));
    run_prog("post_rst", 4);
    prog.push_back(mk_lw(5, 1));
    prog.push_back(mk_alu(6, 1, 5));
    run_prog("rst_lu", 1);
    run_cycle("rst_lu", 1'b1);
    run_prog("post_rst2", 3);

    // Random mix over a small register set
    for (int k = 0; k < 300; k++) begin
      instr_t i;
      case ($urandom_range(0, 5))
        0:       i = mk_nop();
        1, 2:    i = mk_alu($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        3:       i = mk_lw($urandom_range(0, 3), $urandom_range(0, 3));
        4:       i = mk_mult($urandom_range(0, 3), $urandom_range(0, 3));
        default: i = mk_mflo($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 9) == 0) i = flushed(i);
      prog.push_back(i);
    end
    for (int c = 0; c < 3000 && prog.size() != 0; c++) run_cycle("rand");
    if (prog.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL rand_drain left=%0d t=%0t", prog.size(), $time);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
